// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer for an external MAC slice: clears the slice, streams operands and captures P.
// Optional overflow tracking is built when DSP_MAC_SEQ_OVF_EN is defined.
module dsp_mac_seq #(
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned OPM_DLY = 1,
   parameter int unsigned LAT     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [17:0]      in_a,
   input  logic [17:0]      in_b,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_rst,
   input  logic [47:0]      dsp_p,
   output logic [47:0]      res,
   output logic             res_valid,
   input  logic             res_ready,
`ifdef DSP_MAC_SEQ_OVF_EN
   output logic             busy,
   input  logic             dsp_carryout,
   output logic             ovf
`else
   output logic             busy
`endif
);

   localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [7:0] OpFirst = 8'h01;
   localparam logic [7:0] OpAcc   = 8'h09;
   localparam logic [7:0] OpHold  = 8'h08;

   typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [DW-1:0]    drain_cnt_q;
   logic             xfer;
   logic             last_elem;
   logic             drain_last;
   logic             start_acc;
   logic [7:0]       op_src;

   assign xfer       = in_valid && in_ready;
   assign last_elem  = ((cnt_q + LEN_W'(1)) == len_q);
   assign drain_last = (drain_cnt_q == DW'(LAT - 1));
   assign start_acc  = (state_q == StIdle) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = (len == '0) ? StDone : StClr;
         StClr:   state_d = StRun;
         StRun:   if (xfer && last_elem) state_d = StDrain;
         StDrain: if (drain_last) state_d = StDone;
         StDone:  if (res_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The last OPM_DLY drain slots issue hold so dsp_opmode already reads hold in DONE;
   // their operands are zero, so the sum is unaffected.
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      res_valid = 1'b0;
      op_src    = OpHold;
      case (state_q)
         StIdle:  busy = 1'b0;
         StRun: begin
            in_ready = (cnt_q != len_q);
            op_src   = (xfer && (cnt_q == '0)) ? OpFirst : OpAcc;
         end
         StDrain: op_src = (32'(drain_cnt_q) + OPM_DLY < LAT) ? OpAcc : OpHold;
         StDone:  res_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         cnt_q       <= '0;
         drain_cnt_q <= '0;
         dsp_a       <= '0;
         dsp_b       <= '0;
         dsp_rst     <= 1'b1;
         res         <= '0;
      end else begin
         dsp_rst     <= (state_d == StClr);
         dsp_a       <= xfer ? in_a : '0;
         dsp_b       <= xfer ? in_b : '0;
         drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + DW'(1) : '0;
         if (start_acc) begin
            len_q <= len;
            cnt_q <= '0;
         end else if (xfer) begin
            cnt_q <= cnt_q + LEN_W'(1);
         end
         if (start_acc && (len == '0)) begin
            res <= '0;
         end else if ((state_q == StDrain) && drain_last) begin
            res <= dsp_p;
         end
      end
   end

   generate
      if (OPM_DLY == 0) begin : g_opm_comb
         assign dsp_opmode = op_src;
      end else begin : g_opm_pipe
         logic [7:0] opm_q [OPM_DLY];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < OPM_DLY; i++) opm_q[i] <= OpHold;
            end else begin
               opm_q[0] <= op_src;
               for (int i = 1; i < OPM_DLY; i++) opm_q[i] <= opm_q[i-1];
            end
         end
         assign dsp_opmode = opm_q[OPM_DLY-1];
      end
   endgenerate

`ifdef DSP_MAC_SEQ_OVF_EN
   // A zero-length run never visits CLR, so its accept clears the flag too.
   logic ovf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if ((state_q == StClr) || start_acc) begin
         ovf_q <= 1'b0;
      end else if (((state_q == StRun) || (state_q == StDrain)) && dsp_carryout) begin
         ovf_q <= 1'b1;
      end
   end
   assign ovf = ovf_q;
`endif

endmodule
